peripherals_gpio: RTL and testbench

Memory-mapped GPIO controller replacing the fixed 4-in/4-out peripheral port with parametrised channel counts. Sits on the data-memory bus beside RAM and is selected by the memory decoder. Inputs pass through a 2-flop synchroniser and a per-channel debouncer. Rising edges latch sticky event flags that drive a maskable interrupt line. Outputs are a register with atomic set and clear aliases.

---
 rtl/gpio_pkg.sv | 15 +
 rtl/gpio_debounce.sv | 67 ++++++
 rtl/peripherals_gpio.sv | 99 +++++++++
 tb/tb_peripherals_gpio.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Register map and address decode constants for the memory-mapped GPIO block.
package gpio_pkg;

    localparam int ADDR_SEL_LSB = 2;
    localparam int ADDR_SEL_MSB = 4;
    localparam int SEL_W        = ADDR_SEL_MSB - ADDR_SEL_LSB + 1;

    localparam logic [SEL_W-1:0] REG_IN    = 3'd0;
    localparam logic [SEL_W-1:0] REG_OUT   = 3'd1;
    localparam logic [SEL_W-1:0] REG_SET   = 3'd2;
    localparam logic [SEL_W-1:0] REG_CLR   = 3'd3;
    localparam logic [SEL_W-1:0] REG_EVENT = 3'd4;
    localparam logic [SEL_W-1:0] REG_MASK  = 3'd5;

endpackage

// File: rtl/gpio_debounce.sv
// One input channel: two-flop synchroniser followed by a stability counter.
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], raw};
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign stable = sync_q[1];
        end else begin : g_count
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          stable_q;
            logic          stable_d;

            // The count only advances while the synced value disagrees with
            // the accepted state, so any reversal restarts it from zero.
            always_comb begin
                cnt_d    = cnt_q;
                stable_d = stable_q;
                if (sync_q[1] == stable_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    stable_d = sync_q[1];
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            always_ff @(negedge clock) begin
                if (reset) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end

            assign stable = stable_q;
        end
    endgenerate

endmodule

// File: rtl/peripherals_gpio.sv
// Memory-mapped GPIO: debounced inputs with sticky rising-edge events and a
// maskable interrupt, plus an output register with set/clear aliases.
module peripherals_gpio
    import gpio_pkg::*;
#(
    parameter int               N_IN            = 4,
    parameter int               N_OUT           = 4,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter logic [N_OUT-1:0] OUT_RESET       = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      address,
    input  logic [31:0]      input_data,
    input  logic             should_write,
    input  logic [N_IN-1:0]  input_peripherals,
    output logic [N_OUT-1:0] output_peripherals,
    output logic [31:0]      output_data,
    output logic             irq
);

    logic [SEL_W-1:0] sel;
    logic [N_IN-1:0]  in_stable;
    logic [N_IN-1:0]  in_prev_q,  in_prev_d;
    logic [N_IN-1:0]  event_q,    event_d;
    logic [N_IN-1:0]  mask_q,     mask_d;
    logic [N_OUT-1:0] out_q,      out_d;
    logic             irq_q,      irq_d;
    logic [N_IN-1:0]  wr_in;
    logic [N_OUT-1:0] wr_out;

    assign sel    = address[ADDR_SEL_MSB:ADDR_SEL_LSB];
    assign wr_in  = input_data[N_IN-1:0];
    assign wr_out = input_data[N_OUT-1:0];

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_in
            gpio_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clock (clock),
                .reset (reset),
                .raw   (input_peripherals[gi]),
                .stable(in_stable[gi])
            );
        end
    endgenerate

    always_comb begin
        out_d     = out_q;
        mask_d    = mask_q;
        event_d   = event_q;
        in_prev_d = in_stable;
        if (should_write) begin
            case (sel)
                REG_OUT:   out_d   = wr_out;
                REG_SET:   out_d   = out_q | wr_out;
                REG_CLR:   out_d   = out_q & ~wr_out;
                REG_EVENT: event_d = event_q & ~wr_in;
                REG_MASK:  mask_d  = wr_in;
                default:   ;
            endcase
        end
        // Applied after the clear so a coincident new edge keeps its flag.
        event_d = event_d | (in_stable & ~in_prev_q);
        irq_d   = |(event_q & mask_q);
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            out_q     <= OUT_RESET;
            mask_q    <= '0;
            event_q   <= '0;
            in_prev_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            mask_q    <= mask_d;
            event_q   <= event_d;
            in_prev_q <= in_prev_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        output_data = '0;
        case (sel)
            REG_IN:                    output_data[N_IN-1:0]  = in_stable;
            REG_OUT, REG_SET, REG_CLR: output_data[N_OUT-1:0] = out_q;
            REG_EVENT:                 output_data[N_IN-1:0]  = event_q;
            REG_MASK:                  output_data[N_IN-1:0]  = mask_q;
            default:                   ;
        endcase
    end

    assign output_peripherals = out_q;
    assign irq                = irq_q;

endmodule

// File: tb/tb_peripherals_gpio.sv
// Bench for peripherals_gpio: two configurations (debounced 4/4 and bypassed 8/2)
// checked by directed scenarios and a randomized run against a behavioural model.
module tb_peripherals_gpio;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        we    [2];
    logic [31:0] pins  [2];

    logic [3:0]  outp_a;
    logic [1:0]  outp_b;
    logic [31:0] rdata_a, rdata_b;
    logic        irq_a, irq_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    peripherals_gpio #(
        .N_IN(4), .N_OUT(4), .DEBOUNCE_CYCLES(16), .OUT_RESET(4'b1010)
    ) dut_a (
        .clock(clk), .reset(rst), .address(addr[0]), .input_data(wdata[0]),
        .should_write(we[0]), .input_peripherals(pins[0][3:0]),
        .output_peripherals(outp_a), .output_data(rdata_a), .irq(irq_a)
    );

    peripherals_gpio #(
        .N_IN(8), .N_OUT(2), .DEBOUNCE_CYCLES(0), .OUT_RESET(2'b00)
    ) dut_b (
        .clock(clk), .reset(rst), .address(addr[1]), .input_data(wdata[1]),
        .should_write(we[1]), .input_peripherals(pins[1][7:0]),
        .output_peripherals(outp_b), .output_data(rdata_b), .irq(irq_b)
    );

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_in      [2];
    logic [31:0] m_in_last [2];
    logic [31:0] m_ev      [2];
    logic [31:0] m_mask    [2];
    logic [31:0] m_out     [2];
    logic        m_irq     [2];
    logic [31:0] m_hist    [2][18];  // m_hist[k][j]: pin sample taken j+1 edges ago

    function automatic logic [31:0] in_msk(int k);
        return (k == 0) ? 32'hF : 32'hFF;
    endfunction
    function automatic logic [31:0] out_msk(int k);
        return (k == 0) ? 32'hF : 32'h3;
    endfunction
    function automatic int dcyc(int k);
        return (k == 0) ? 16 : 0;
    endfunction

    function automatic logic [31:0] m_read(int k, logic [31:0] a);
        logic [2:0] r;
        r = a[4:2];
        case (r)
            3'd0:             return m_in[k];
            3'd1, 3'd2, 3'd3: return m_out[k];
            3'd4:             return m_ev[k];
            3'd5:             return m_mask[k];
            default:          return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] dut_rdata(int k);
        return (k == 0) ? rdata_a : rdata_b;
    endfunction

    task automatic model_reset(int k);
        m_in[k]      = 0;
        m_in_last[k] = 0;
        m_ev[k]      = 0;
        m_mask[k]    = 0;
        m_out[k]     = (k == 0) ? 32'hA : 32'h0;
        m_irq[k]     = 1'b0;
        for (int j = 0; j < 18; j++) m_hist[k][j] = 0;
    endtask

    task automatic model_edge(int k);
        logic [31:0] nin, rise, w1c, d, im;
        logic        all_other;
        if (rst) begin
            model_reset(k);
        end else begin
            im = in_msk(k);
            d  = wdata[k];
            m_irq[k] = |(m_ev[k] & m_mask[k]);
            rise = m_in[k] & ~m_in_last[k];
            w1c = 0;
            if (we[k]) begin
                case (addr[k][4:2])
                    3'd1: m_out[k]  = d & out_msk(k);
                    3'd2: m_out[k]  = (m_out[k] | d) & out_msk(k);
                    3'd3: m_out[k]  = m_out[k] & ~d;
                    3'd4: w1c       = d;
                    3'd5: m_mask[k] = d & im;
                    default: ;
                endcase
            end
            m_ev[k] = ((m_ev[k] & ~w1c) | rise) & im;
            // Input accepted once the last D synchronised samples all hold the new level.
            if (dcyc(k) == 0) begin
                nin = m_hist[k][0];
            end else begin
                nin = m_in[k];
                for (int c = 0; c < 32; c++) begin
                    if (im[c]) begin
                        all_other = 1'b1;
                        for (int j = 1; j <= dcyc(k); j++)
                            if (m_hist[k][j][c] == m_in[k][c]) all_other = 1'b0;
                        if (all_other) nin[c] = ~m_in[k][c];
                    end
                end
            end
            m_in_last[k] = m_in[k];
            m_in[k]      = nin & im;
            for (int j = 17; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
            m_hist[k][0] = pins[k] & im;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        we[0] = 1'b0;
        we[1] = 1'b0;
    endtask

    task automatic wr(int k, logic [31:0] a, logic [31:0] d);
        addr[k]  = a;
        wdata[k] = d;
        we[k]    = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] ra [3];
        ra = '{32'h00, 32'h10, 32'h14};
        rst = 1'b1;
        pins[0] = 0;
        pins[1] = 0;
        tick();
        wr(0, 32'h04, 32'hF);
        tick();
        rst = 1'b0;
        checks++;
        if (outp_a !== 4'b1010) begin
            errors++;
            $display("FAIL reset_out_a: got %h expected %h", outp_a, 4'b1010);
        end
        checks++;
        if (irq_a !== 1'b0 || irq_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b/%b expected 0/0", irq_a, irq_b);
        end
        checks++;
        if (outp_b !== 2'b00) begin
            errors++;
            $display("FAIL reset_out_b: got %h expected 0", outp_b);
        end
        for (int i = 0; i < 3; i++) begin
            addr[0] = ra[i];
            #1;
            checks++;
            if (rdata_a !== 32'h0) begin
                errors++;
                $display("FAIL reset_read addr=%h: got %h expected 0", ra[i], rdata_a);
            end
        end
    endtask

    task automatic test_outputs();
        logic [31:0] wa [3];
        logic [31:0] wd [3];
        logic [3:0]  ex [3];
        logic [3:0]  prev;
        wa = '{32'h04, 32'h08, 32'h0C};
        wd = '{32'h5, 32'h2, 32'h4};
        ex = '{4'h5, 4'h7, 4'h3};
        prev = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            wr(0, wa[i], wd[i]);
            #1;
            checks++;
            if (outp_a !== prev) begin
                errors++;
                $display("FAIL out_before_edge[%0d]: got %h expected %h", i, outp_a, prev);
            end
            tick();
            checks++;
            if (outp_a !== ex[i]) begin
                errors++;
                $display("FAIL out_pins[%0d]: got %h expected %h", i, outp_a, ex[i]);
            end
            addr[0] = 32'h04;
            #1;
            checks++;
            if (rdata_a !== {28'h0, ex[i]}) begin
                errors++;
                $display("FAIL out_read[%0d]: got %h expected %h", i, rdata_a, ex[i]);
            end
            prev = ex[i];
        end
    endtask

    task automatic test_debounce();
        int seen = 0;
        int n = 0;
        bit found = 0;
        addr[0] = 32'h00;
        pins[0][2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rdata_a[2]) seen++;
        end
        pins[0][2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rdata_a[2]) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL debounce_pulse: IN bit2 seen high %0d cycles, expected 0", seen);
        end
        pins[0][2] = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            n++;
            if (rdata_a[2]) found = 1;
        end
        checks++;
        if (!found || n != 18) begin
            errors++;
            $display("FAIL debounce_latency: found=%0d after %0d cycles, expected 18", found, n);
        end
        tick();
        addr[0] = 32'h10;
        #1;
        checks++;
        if (rdata_a !== 32'h4) begin
            errors++;
            $display("FAIL event_after_rise: got %h expected 4", rdata_a);
        end
    endtask

    task automatic test_irq();
        tick();
        checks++;
        if (irq_a !== 1'b0) begin
            errors++;
            $display("FAIL irq_masked: got %b expected 0", irq_a);
        end
        wr(0, 32'h14, 32'h4);
        tick();
        checks++;
        if (irq_a !== 1'b0) begin
            errors++;
            $display("FAIL irq_mask_edge: got %b expected 0", irq_a);
        end
        tick();
        checks++;
        if (irq_a !== 1'b1) begin
            errors++;
            $display("FAIL irq_raise: got %b expected 1", irq_a);
        end
        wr(0, 32'h10, 32'h4);
        tick();
        addr[0] = 32'h10;
        #1;
        checks++;
        if (rdata_a !== 32'h0 || irq_a !== 1'b1) begin
            errors++;
            $display("FAIL w1c_clear: event=%h irq=%b expected event=0 irq=1", rdata_a, irq_a);
        end
        tick();
        checks++;
        if (irq_a !== 1'b0) begin
            errors++;
            $display("FAIL irq_drop: got %b expected 0", irq_a);
        end
    endtask

    task automatic test_collision();
        bit fell = 0;
        bit rose = 0;
        addr[0] = 32'h00;
        pins[0][2] = 1'b0;
        for (int i = 0; i < 40 && !fell; i++) begin
            tick();
            if (!rdata_a[2]) fell = 1;
        end
        pins[0][2] = 1'b1;
        for (int i = 0; i < 40 && !rose; i++) begin
            tick();
            if (rdata_a[2]) rose = 1;
        end
        checks++;
        if (!fell || !rose) begin
            errors++;
            $display("FAIL collision_setup: fell=%0d rose=%0d expected 1/1", fell, rose);
        end
        wr(0, 32'h10, 32'h4);
        tick();
        addr[0] = 32'h10;
        #1;
        checks++;
        if (rdata_a !== 32'h4) begin
            errors++;
            $display("FAIL collision_set_wins: got %h expected 4", rdata_a);
        end
    endtask

    task automatic test_cfg_b();
        int n = 0;
        bit found = 0;
        addr[1] = 32'h00;
        pins[1][5] = 1'b1;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            n++;
            if (rdata_b[5]) found = 1;
        end
        checks++;
        if (!found || n != 2) begin
            errors++;
            $display("FAIL bypass_latency: found=%0d after %0d cycles, expected 2", found, n);
        end
        wr(1, 32'h04, 32'hFF);
        tick();
        addr[1] = 32'h04;
        #1;
        checks++;
        if (rdata_b !== 32'h3 || outp_b !== 2'b11) begin
            errors++;
            $display("FAIL narrow_out: read=%h pins=%b expected 3/11", rdata_b, outp_b);
        end
        addr[1] = 32'h10;
        #1;
        checks++;
        if (rdata_b !== 32'h20) begin
            errors++;
            $display("FAIL bypass_event: got %h expected 20", rdata_b);
        end
        wr(1, 32'h18, 32'hFFFF_FFFF);
        tick();
        addr[1] = 32'h18;
        #1;
        checks++;
        if (rdata_b !== 32'h0) begin
            errors++;
            $display("FAIL unused_read: got %h expected 0", rdata_b);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_r;
        for (int cyc = 0; cyc < 500; cyc++) begin
            checks++;
            if (outp_a !== m_out[0][3:0] || outp_b !== m_out[1][1:0]) begin
                errors++;
                $display("FAIL rand_out cyc=%0d: got %h/%h expected %h/%h",
                         cyc, outp_a, outp_b, m_out[0][3:0], m_out[1][1:0]);
            end
            checks++;
            if (irq_a !== m_irq[0] || irq_b !== m_irq[1]) begin
                errors++;
                $display("FAIL rand_irq cyc=%0d: got %b/%b expected %b/%b",
                         cyc, irq_a, irq_b, m_irq[0], m_irq[1]);
            end
            rst = ($urandom_range(0, 149) == 0);
            for (int k = 0; k < 2; k++) begin
                addr[k]  = $urandom;
                wdata[k] = $urandom;
                we[k]    = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, (k == 0) ? 9 : 3) == 0)
                    pins[k][$urandom_range(0, (k == 0) ? 3 : 7)] ^= 1'b1;
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                exp_r = m_read(k, addr[k]);
                checks++;
                if (dut_rdata(k) !== exp_r) begin
                    errors++;
                    $display("FAIL rand_read dut%0d cyc=%0d addr=%h: got %h expected %h",
                             k, cyc, addr[k], dut_rdata(k), exp_r);
                end
            end
            tick();
            rst = 1'b0;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            addr[k]  = 0;
            wdata[k] = 0;
            we[k]    = 1'b0;
            pins[k]  = 0;
            model_reset(k);
        end
        @(posedge clk);
        #1;
        test_reset();
        test_outputs();
        test_debounce();
        test_irq();
        test_collision();
        test_cfg_b();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
